// File: rtl/uart_rx_cfg_pkg.sv
// Shared types and layout helpers for the configurable UART receiver.
package uart_rx_cfg_pkg;

   // Receiver FSM states
   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } rx_state_e;

   // FIFO entry layout from LSB: data bits, then ferr, then perr
   function automatic int unsigned ferr_pos(input int unsigned data_bits);
      return data_bits;
   endfunction

   function automatic int unsigned perr_pos(input int unsigned data_bits);
      return data_bits + 1;
   endfunction

endpackage

// File: rtl/uart_rx_cfg_fifo.sv
// First-word-fall-through receive FIFO; pointers carry an extra wrap bit.
module uart_rx_cfg_fifo #(
   parameter int unsigned WIDTH = 10,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk,
   input  logic             RST,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [AW:0]      wptr_q, rptr_q;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push, do_pop;

   assign empty   = (wptr_q == rptr_q);
   assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A full FIFO still accepts a word when the head is popped in the same cycle
   assign do_push = push && (!full || do_pop);

   // Pointer update
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + PTR_ONE;
         if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
      end
   end

   // Storage write
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
   end

   assign rdata = empty ? '0 : mem[rptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchroniser, frame FSM, error flags and receive FIFO.
module uart_rx_cfg
   import uart_rx_cfg_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned PARITY_EN  = 0,
   parameter int unsigned PARITY_ODD = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 RST,
   input  logic                 enable,
   input  logic                 rx,
   input  logic                 rd_en,
   input  logic                 clr_err,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 rd_perr,
   output logic                 rd_ferr,
   output logic                 rd_valid,
   output logic                 fifo_full,
   output logic                 overrun_err,
   output logic                 rx_busy,
   output logic                 rx_done
);

   localparam int unsigned CW       = $clog2(OVERSAMPLE);
   localparam int unsigned IW       = $clog2(DATA_BITS + 1);
   localparam int unsigned EW       = DATA_BITS + 2;
   localparam int unsigned FERR_POS = ferr_pos(DATA_BITS);
   localparam int unsigned PERR_POS = perr_pos(DATA_BITS);

   localparam logic [CW-1:0] HALF_TICK = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_TICK = CW'(OVERSAMPLE - 1);
   localparam logic [CW-1:0] CNT_ONE   = CW'(1);
   localparam logic [IW-1:0] IDX_ONE   = IW'(1);
   localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
   localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

   rx_state_e            state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [IW-1:0]        idx_q, idx_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 rx_meta, rx_s;
   logic                 push, pop_ok, ovf;
   logic [EW-1:0]        entry, fifo_rdata;
   logic                 fifo_empty;
   logic                 done_q, overrun_q;

   // Two-flop synchroniser; resets to the idle line level so reset exit is quiet
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
      end
   end

   // Frame FSM next-state, sampling and push decision
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_ONE;
      idx_d   = idx_q;
      data_d  = data_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      push    = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            idx_d = '0;
            if (!rx_s) begin
               state_d = StStart;
               data_d  = '0;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
            end
         end
         StStart: begin
            if (cnt_q == HALF_TICK) begin
               cnt_d   = '0;
               state_d = rx_s ? StIdle : StData;
            end
         end
         StData: begin
            if (cnt_q == FULL_TICK) begin
               cnt_d         = '0;
               data_d[idx_q] = rx_s;
               if (idx_q == LAST_DATA) begin
                  idx_d   = '0;
                  state_d = (PARITY_EN != 0) ? StParity : StStop;
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end
         end
         StParity: begin
            if (cnt_q == FULL_TICK) begin
               cnt_d   = '0;
               perr_d  = ((^data_q) ^ rx_s) != (PARITY_ODD != 0);
               state_d = StStop;
            end
         end
         StStop: begin
            if (cnt_q == FULL_TICK) begin
               cnt_d = '0;
               if (!rx_s) ferr_d = 1'b1;
               if (idx_q == LAST_STOP) begin
                  // Leave at mid stop bit so a back-to-back start edge is not missed
                  push    = 1'b1;
                  idx_d   = '0;
                  state_d = StIdle;
               end else begin
                  idx_d = idx_q + IDX_ONE;
               end
            end
         end
         default: begin
            state_d = StIdle;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase
      // Disabling abandons any partial frame
      if (!enable) begin
         state_d = StIdle;
         cnt_d   = '0;
         idx_d   = '0;
         push    = 1'b0;
      end
   end

   // FSM and datapath registers
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         data_q  <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   // Final stop sample is folded in through ferr_d
   assign entry  = {perr_q, ferr_d, data_q};
   assign pop_ok = rd_en && !fifo_empty;
   assign ovf    = push && fifo_full && !pop_ok;

   // Completion pulse and sticky overrun; a new overrun beats a clear
   always_ff @(posedge clk or negedge RST) begin
      if (!RST) begin
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         done_q <= push;
         if (ovf) begin
            overrun_q <= 1'b1;
         end else if (clr_err) begin
            overrun_q <= 1'b0;
         end
      end
   end

   uart_rx_cfg_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .RST   (RST),
      .push  (push),
      .wdata (entry),
      .pop   (rd_en),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rd_data     = fifo_rdata[DATA_BITS-1:0];
   assign rd_ferr     = fifo_rdata[FERR_POS];
   assign rd_perr     = fifo_rdata[PERR_POS];
   assign rd_valid    = !fifo_empty;
   assign overrun_err = overrun_q;
   assign rx_busy     = (state_q != StIdle);
   assign rx_done     = done_q;

endmodule
